// File: rtl/alu_pkg.sv
// Shared definitions for the multi-word ALU sequencer: ALU opcodes, FSM states and
// request operation codes.
package alu_pkg;

    localparam logic [4:0] ALU_OP_ADD  = 5'b00000;
    localparam logic [4:0] ALU_OP_ADDC = 5'b00001;
    localparam logic [4:0] ALU_OP_INC  = 5'b00011;
    localparam logic [4:0] ALU_OP_SUBB = 5'b00100;
    localparam logic [4:0] ALU_OP_SUB  = 5'b00101;
    localparam logic [4:0] ALU_OP_DEC  = 5'b00110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        REQ_ADD = 2'b00,
        REQ_SUB = 2'b01,
        REQ_INC = 2'b10,
        REQ_DEC = 2'b11
    } req_op_t;

endpackage

// File: rtl/alu_op_sel.sv
// Maps (request op, first-word flag, chained carry/borrow) to the single-word ALU opcode.
// Optional inc/dec ops are enabled by defining ALU_SEQ_INCDEC_EN.
module alu_op_sel
    import alu_pkg::*;
(
    input  req_op_t    i_op,
    input  logic       i_first,
    input  logic       i_carry,
    output logic [4:0] o_alu_op
);

    logic w_chain;

    // Later words pick the carry/borrow-consuming opcode only when the previous word produced one.
    assign w_chain = !i_first && i_carry;

    always_comb begin
        o_alu_op = ALU_OP_ADD;
`ifdef ALU_SEQ_INCDEC_EN
        case (i_op)
            REQ_ADD: o_alu_op = w_chain ? ALU_OP_ADDC : ALU_OP_ADD;
            REQ_SUB: o_alu_op = w_chain ? ALU_OP_SUBB : ALU_OP_SUB;
            REQ_INC: o_alu_op = (i_first || i_carry) ? ALU_OP_INC : ALU_OP_ADD;
            REQ_DEC: o_alu_op = (i_first || i_carry) ? ALU_OP_DEC : ALU_OP_SUB;
            default: o_alu_op = ALU_OP_ADD;
        endcase
`else
        case (i_op)
            REQ_ADD, REQ_INC: o_alu_op = w_chain ? ALU_OP_ADDC : ALU_OP_ADD;
            REQ_SUB, REQ_DEC: o_alu_op = w_chain ? ALU_OP_SUBB : ALU_OP_SUB;
            default:          o_alu_op = ALU_OP_ADD;
        endcase
`endif
    end

endmodule

// File: rtl/alu_word_seq.sv
// Multi-word add/sub sequencer: issues one word per cycle (LSW first) to a single-word ALU,
// chains carry/borrow via opcode choice. Define ALU_SEQ_INCDEC_EN to enable inc/dec ops.
module alu_word_seq
    import alu_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int WORDS = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    // Both handshakes: a transfer happens on a rising edge where VALID and READY are high.
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [1:0]            REQ_OP,
    input  logic [BITS*WORDS-1:0] REQ_A,
    input  logic [BITS*WORDS-1:0] REQ_B,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [BITS*WORDS-1:0] RSP_RESU,
    output logic                  RSP_O,
    output logic                  RSP_C,
    output logic                  RSP_S,
    output logic                  RSP_Z,
    output logic [BITS-1:0]       ALU_A,
    output logic [BITS-1:0]       ALU_B,
    output logic [4:0]            ALU_OP,
    input  logic [BITS-1:0]       ALU_RESU,
    input  logic                  ALU_O,
    input  logic                  ALU_C,
    input  logic                  ALU_S,
    input  logic                  ALU_Z,
    output seq_state_t            o_dbg_state
);

    localparam int N     = BITS * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    seq_state_t       r_state;
    seq_state_t       w_next;
    req_op_t          r_op;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_resu;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_zacc;
    logic             r_o;
    logic             r_c;
    logic             r_s;
    logic             r_z;
    logic             w_last;
    logic             w_first;
    logic             w_b_zero;
    logic [4:0]       w_sel_op;

    assign w_last  = (r_idx == LAST_IDX);
    assign w_first = (r_idx == '0);

`ifdef ALU_SEQ_INCDEC_EN
    assign w_b_zero = (r_op == REQ_INC) || (r_op == REQ_DEC);
`else
    assign w_b_zero = 1'b0;
`endif

    alu_op_sel u_op_sel (
        .i_op     (r_op),
        .i_first  (w_first),
        .i_carry  (r_carry),
        .o_alu_op (w_sel_op)
    );

    always_comb begin
        w_next    = r_state;
        REQ_READY = 1'b0;
        RSP_VALID = 1'b0;
        ALU_A     = '0;
        ALU_B     = '0;
        ALU_OP    = ALU_OP_ADD;
        case (r_state)
            ST_IDLE: begin
                REQ_READY = 1'b1;
                if (REQ_VALID) w_next = ST_RUN;
            end
            ST_RUN: begin
                ALU_A  = r_a[r_idx*BITS +: BITS];
                ALU_B  = w_b_zero ? '0 : r_b[r_idx*BITS +: BITS];
                ALU_OP = w_sel_op;
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_op    <= REQ_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_resu  <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_zacc  <= 1'b0;
            r_o     <= 1'b0;
            r_c     <= 1'b0;
            r_s     <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        r_a     <= REQ_A;
                        r_b     <= REQ_B;
                        r_op    <= req_op_t'(REQ_OP);
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                        r_zacc  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_resu[r_idx*BITS +: BITS] <= ALU_RESU;
                    r_carry <= ALU_C;
                    r_zacc  <= r_zacc & ALU_Z;
                    // Only the final word's O/C/S are meaningful for the whole operand.
                    if (w_last) begin
                        r_o <= ALU_O;
                        r_c <= ALU_C;
                        r_s <= ALU_S;
                        r_z <= r_zacc & ALU_Z;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign RSP_RESU    = r_resu;
    assign RSP_O       = r_o;
    assign RSP_C       = r_c;
    assign RSP_S       = r_s;
    assign RSP_Z       = r_z;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_word_seq.sv
// Bench for alu_word_seq: attaches a behavioural single-word ALU and checks every response
// against a whole-operand arithmetic model, plus directed literal cases.
module tb_alu_word_seq;
    import alu_pkg::*;

    localparam int BITS  = 8;
    localparam int WORDS = 4;
    localparam int N     = BITS * WORDS;
    localparam int EW    = N + 4;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADDC = 5'b00001;
    localparam logic [4:0] OP_INC  = 5'b00011;
    localparam logic [4:0] OP_SUBB = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_DEC  = 5'b00110;

    logic            CLK;
    logic            RST;
    logic            REQ_VALID;
    logic            REQ_READY;
    logic [1:0]      REQ_OP;
    logic [N-1:0]    REQ_A;
    logic [N-1:0]    REQ_B;
    logic            RSP_VALID;
    logic            RSP_READY;
    logic [N-1:0]    RSP_RESU;
    logic            RSP_O, RSP_C, RSP_S, RSP_Z;
    logic [BITS-1:0] ALU_A, ALU_B, ALU_RESU;
    logic [4:0]      ALU_OP;
    logic            ALU_O, ALU_C, ALU_S, ALU_Z;
    seq_state_t      dbg_state;

    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic rdy_mode  = 1'b0;
    logic rdy_force = 1'b1;

    alu_word_seq #(.BITS(BITS), .WORDS(WORDS)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_A(REQ_A), .REQ_B(REQ_B),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RESU(RSP_RESU),
        .RSP_O(RSP_O), .RSP_C(RSP_C), .RSP_S(RSP_S), .RSP_Z(RSP_Z),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_RESU(ALU_RESU),
        .ALU_O(ALU_O), .ALU_C(ALU_C), .ALU_S(ALU_S), .ALU_Z(ALU_Z),
        .o_dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- single-word ALU model ----------------
    logic [BITS:0] alu_t;
    logic          alu_sub;
    always_comb begin
        alu_t   = '0;
        alu_sub = 1'b0;
        case (ALU_OP)
            OP_ADD:  alu_t = {1'b0, ALU_A} + {1'b0, ALU_B};
            OP_ADDC: alu_t = {1'b0, ALU_A} + {1'b0, ALU_B} + 1'b1;
            OP_INC:  alu_t = {1'b0, ALU_A} + 1'b1;
            OP_SUB:  begin alu_t = {1'b0, ALU_A} - {1'b0, ALU_B};        alu_sub = 1'b1; end
            OP_SUBB: begin alu_t = {1'b0, ALU_A} - {1'b0, ALU_B} - 1'b1; alu_sub = 1'b1; end
            OP_DEC:  begin alu_t = {1'b0, ALU_A} - 1'b1;                 alu_sub = 1'b1; end
            default: alu_t = '0;
        endcase
        ALU_RESU = alu_t[BITS-1:0];
        ALU_C    = alu_t[BITS];
        ALU_S    = alu_t[BITS-1];
        ALU_Z    = (alu_t[BITS-1:0] == '0);
        if (alu_sub)
            ALU_O = (ALU_A[BITS-1] != ALU_B[BITS-1]) && (alu_t[BITS-1] != ALU_A[BITS-1]);
        else
            ALU_O = (ALU_A[BITS-1] == ALU_B[BITS-1]) && (alu_t[BITS-1] != ALU_A[BITS-1]);
    end

    // ---------------- whole-operand reference model ----------------
    function automatic logic [EW-1:0] model(input logic [1:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        logic [N:0]   w;
        logic [N-1:0] r;
        logic         o;
        logic         c;
        logic [1:0]   eop;
        w = '0;
`ifdef ALU_SEQ_INCDEC_EN
        eop = op;
`else
        eop = {1'b0, op[0]};
`endif
        case (eop)
            2'b00: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[N-1:0];
                c = w[N];
                o = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
            end
            2'b01: begin
                r = a - b;
                c = (a < b);
                o = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
            end
            2'b10: begin
                r = a + N'(1);
                c = (a == {N{1'b1}});
                o = (a == {1'b0, {(N-1){1'b1}}});
            end
            default: begin
                r = a - N'(1);
                c = (a == '0);
                o = (a == {1'b1, {(N-1){1'b0}}});
            end
        endcase
        return {o, c, r[N-1], (r == '0), r};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected event within bound", name);
    endtask

    // ---------------- consumer ready driver ----------------
    initial begin
        RSP_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #2;
            RSP_READY = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge CLK) begin
        if (!RST) begin
            check("req_rsp_exclusive", {REQ_READY, RSP_VALID} == 2'b11, 1'b0);
            if (REQ_READY || RSP_VALID)
                check("alu_idle_outputs", {ALU_OP, ALU_A, ALU_B}, '0);
            if (RSP_VALID) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("rsp_unexpected");
                end else begin
                    check("rsp_data", {RSP_O, RSP_C, RSP_S, RSP_Z, RSP_RESU}, exp_q[0]);
                    if (RSP_READY) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        int guard;
        guard = 0;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b1;
        REQ_OP    = op;
        REQ_A     = a;
        REQ_B     = b;
        @(negedge CLK);
        while (!REQ_READY && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        if (!REQ_READY) timeout_fail("req_accept");
        else exp_q.push_back(model(op, a, b));
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        REQ_OP    = 2'($urandom_range(0, 3));
        REQ_A     = $urandom;
        REQ_B     = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end while (!RSP_VALID && lat < 40);
        if (!RSP_VALID) timeout_fail("rsp_wait");
    endtask

    task automatic directed(input string name, input logic [1:0] op, input logic [N-1:0] a,
                            input logic [N-1:0] b, input logic [EW-1:0] exp);
        int lat;
        check({name, "_model"}, model(op, a, b), exp);
        rdy_mode  = 1'b0;
        rdy_force = 1'b1;
        send(op, a, b);
        wait_valid(lat);
        check({name, "_latency"}, lat, WORDS);
        check({name, "_rsp"}, {RSP_O, RSP_C, RSP_S, RSP_Z, RSP_RESU}, exp);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check({name, "_ready_back"}, {REQ_READY, RSP_VALID}, 2'b10);
    endtask

    function automatic logic [N-1:0] pick(input int sel);
        case (sel)
            0: pick = {N{1'b1}};
            1: pick = '0;
            2: pick = {1'b1, {(N-1){1'b0}}};
            3: pick = {1'b0, {(N-1){1'b1}}};
            4: pick = N'(1);
            default: pick = $urandom;
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int guard;
        RST       = 1'b1;
        REQ_VALID = 1'b0;
        REQ_OP    = 2'b00;
        REQ_A     = '0;
        REQ_B     = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("reset_state", dbg_state, ST_IDLE);
        check("reset_handshake", {REQ_READY, RSP_VALID}, 2'b10);
        check("reset_rsp", {RSP_O, RSP_C, RSP_S, RSP_Z, RSP_RESU}, '0);
        check("reset_alu_op", ALU_OP, 5'b00000);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        directed("add_carry_chain", 2'b00, 32'h00FF_FFFF, 32'h0000_0001, {4'b0000, 32'h0100_0000});
        directed("sub_borrow_all", 2'b01, 32'h0000_0000, 32'h0000_0001, {4'b0110, 32'hFFFF_FFFF});
        directed("add_overflow", 2'b00, 32'h7FFF_FFFF, 32'h0000_0001, {4'b1010, 32'h8000_0000});
        directed("sub_zero", 2'b01, 32'h1234_5678, 32'h1234_5678, {4'b0001, 32'h0000_0000});
`ifdef ALU_SEQ_INCDEC_EN
        directed("inc_wrap", 2'b10, 32'hFFFF_FFFF, 32'h1234_5678, {4'b0101, 32'h0000_0000});
        directed("dec_wrap", 2'b11, 32'h0000_0000, 32'h0000_0000, {4'b0110, 32'hFFFF_FFFF});
`else
        directed("op10_as_add", 2'b10, 32'h0000_0005, 32'h0000_0007, {4'b0000, 32'h0000_000C});
        directed("op11_as_sub", 2'b11, 32'h0000_0010, 32'h0000_0001, {4'b0000, 32'h0000_000F});
`endif

        // Response stall: outputs held while the consumer is not ready.
        rdy_mode  = 1'b0;
        rdy_force = 1'b0;
        send(2'b00, 32'h0000_00FF, 32'h0000_0101);
        wait_valid(lat);
        check("stall_latency", lat, WORDS);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            check("stall_hold", {RSP_O, RSP_C, RSP_S, RSP_Z, RSP_RESU}, {4'b0000, 32'h0000_0200});
            check("stall_flags", {REQ_READY, RSP_VALID}, 2'b01);
        end
        @(posedge CLK);
        #1;
        rdy_force = 1'b1;
        @(negedge CLK);
        check("stall_still_valid", RSP_VALID, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        check("stall_release", {REQ_READY, RSP_VALID}, 2'b10);

        // Reset in the middle of a run, while the third word is on the ALU.
        send(2'b00, 32'h0101_0101, 32'h0202_0202);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        exp_q.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check("midrun_reset_state", dbg_state, ST_IDLE);
        check("midrun_reset_handshake", {REQ_READY, RSP_VALID}, 2'b10);
        check("midrun_reset_alu_op", ALU_OP, 5'b00000);
        directed("after_reset_add", 2'b00, 32'h0000_0001, 32'h0000_0001, {4'b0000, 32'h0000_0002});

        // Randomized traffic with a randomly stalling consumer.
        rdy_mode = 1'b1;
        for (int i = 0; i < 60; i++)
            send(2'($urandom_range(0, 3)), pick($urandom_range(0, 8)), pick($urandom_range(0, 8)));
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (exp_q.size() != 0) timeout_fail("random_drain");
        rdy_mode  = 1'b0;
        rdy_force = 1'b1;
        repeat (3) @(posedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got time limit expected end of test");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
